fp_div_32: RTL and testbench



---
 rtl/fp_div_32.sv | 213 +++++++++++++++++++++
 tb/tb_fp_div_32.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_32.sv
// Iterative IEEE-754 single-precision divider: radix-2 restoring mantissa loop,
// round-to-nearest-even, flush-to-zero on inputs and outputs, fixed 28-cycle latency.
module fp_div_32 #(
  parameter int unsigned LOOP_BITS = 26
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_data_one,
  input  logic [31:0] i_data_two,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_div_zero,
  output logic        o_invalid
);

  typedef enum logic [1:0] {StIdle, StDivide, StRound, StDone} state_e;
  typedef enum logic [2:0] {SpNone, SpInvalid, SpDivZero, SpInf, SpZero} special_e;

  state_e                 state_q;
  special_e               special_q;
  logic [4:0]             cnt_q;
  logic [LOOP_BITS-1:0]   rem_q;
  logic [LOOP_BITS-1:0]   quo_q;
  logic [23:0]            mb_q;
  logic [7:0]             e1_q;
  logic [7:0]             e2_q;
  logic                   sign_q;
  logic [31:0]            res_data_q;
  logic                   res_dz_q;
  logic                   res_inv_q;

  // Operand classification (subnormals count as zero).
  logic     a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  special_e special_d;
  logic     start_acc;

  always_comb begin
    a_zero = (i_data_one[30:23] == 8'd0);
    b_zero = (i_data_two[30:23] == 8'd0);
    a_inf  = (i_data_one[30:23] == 8'hff) && (i_data_one[22:0] == 23'd0);
    b_inf  = (i_data_two[30:23] == 8'hff) && (i_data_two[22:0] == 23'd0);
    a_nan  = (i_data_one[30:23] == 8'hff) && (i_data_one[22:0] != 23'd0);
    b_nan  = (i_data_two[30:23] == 8'hff) && (i_data_two[22:0] != 23'd0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_d = SpInvalid;
    end else if (b_zero && !a_inf) begin
      special_d = SpDivZero;
    end else if (a_inf) begin
      special_d = SpInf;
    end else if (b_inf || a_zero) begin
      special_d = SpZero;
    end else begin
      special_d = SpNone;
    end
    start_acc = i_start && ((state_q == StIdle) || (state_q == StDone));
  end

  // Trial subtraction rem - Mb as a ripple add of the inverted divisor with carry-in 1.
  logic [LOOP_BITS-1:0] nmb;
  logic [LOOP_BITS-1:0] trial;
  logic [LOOP_BITS:0]   carry;
  logic                 no_borrow;

  always_comb begin
    nmb      = ~{{(LOOP_BITS - 24){1'b0}}, mb_q};
    carry    = '0;
    carry[0] = 1'b1;
    trial    = '0;
    for (int i = 0; i < LOOP_BITS; i++) begin
      trial[i]   = rem_q[i] ^ nmb[i] ^ carry[i];
      carry[i+1] = (rem_q[i] & nmb[i]) | (carry[i] & (rem_q[i] ^ nmb[i]));
    end
    no_borrow = carry[LOOP_BITS];
  end

  // Normalise, round, range-check and apply special-case overrides.
  logic [23:0]       mant;
  logic [24:0]       mant_sum;
  logic [23:0]       mant_r;
  logic              guard_bit;
  logic              sticky_bit;
  logic              rnd_up;
  logic signed [9:0] e_pre;
  logic signed [9:0] e_r;
  logic [31:0]       res_data_d;
  logic              res_dz_d;
  logic              res_inv_d;

  always_comb begin
    if (quo_q[LOOP_BITS-1]) begin
      mant       = quo_q[LOOP_BITS-1 -: 24];
      guard_bit  = quo_q[1];
      sticky_bit = quo_q[0] | (|rem_q);
      e_pre      = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd127;
    end else begin
      mant       = quo_q[LOOP_BITS-2 -: 24];
      guard_bit  = quo_q[0];
      sticky_bit = |rem_q;
      e_pre      = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd126;
    end
    rnd_up   = guard_bit & (sticky_bit | mant[0]);
    mant_sum = {1'b0, mant} + {24'd0, rnd_up};
    if (mant_sum[24]) begin
      mant_r = 24'h800000;
      e_r    = e_pre + 10'sd1;
    end else begin
      mant_r = mant_sum[23:0];
      e_r    = e_pre;
    end

    res_dz_d  = 1'b0;
    res_inv_d = 1'b0;
    if (e_r >= 10'sd255) begin
      res_data_d = {sign_q, 31'h7f800000};
    end else if (e_r <= 10'sd0) begin
      res_data_d = {sign_q, 31'd0};
    end else begin
      res_data_d = {sign_q, e_r[7:0], mant_r[22:0]};
    end

    unique case (special_q)
      SpInvalid: begin
        res_data_d = 32'h7fc00000;
        res_inv_d  = 1'b1;
      end
      SpDivZero: begin
        res_data_d = {sign_q, 31'h7f800000};
        res_dz_d   = 1'b1;
      end
      SpInf:     res_data_d = {sign_q, 31'h7f800000};
      SpZero:    res_data_d = {sign_q, 31'd0};
      default:   ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      special_q  <= SpNone;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      mb_q       <= '0;
      e1_q       <= '0;
      e2_q       <= '0;
      sign_q     <= 1'b0;
      res_data_q <= '0;
      res_dz_q   <= 1'b0;
      res_inv_q  <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_div_zero <= 1'b0;
      o_invalid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_q    <= StDivide;
            o_busy     <= 1'b1;
            o_div_zero <= 1'b0;
            o_invalid  <= 1'b0;
          end
        end
        StDivide: begin
          quo_q <= {quo_q[LOOP_BITS-2:0], no_borrow};
          rem_q <= no_borrow ? (trial << 1) : (rem_q << 1);
          if (cnt_q == 5'd0) begin
            state_q <= StRound;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        StRound: begin
          res_data_q <= res_data_d;
          res_dz_q   <= res_dz_d;
          res_inv_q  <= res_inv_d;
          state_q    <= StDone;
        end
        StDone: begin
          o_data     <= res_data_q;
          o_div_zero <= res_dz_q;
          o_invalid  <= res_inv_q;
          o_valid    <= 1'b1;
          if (i_start) begin
            state_q <= StDivide;
          end else begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Operand capture shared by the IDLE and DONE start paths.
      if (start_acc) begin
        cnt_q     <= 5'(LOOP_BITS - 1);
        rem_q     <= {{(LOOP_BITS - 24){1'b0}}, 1'b1, i_data_one[22:0]};
        quo_q     <= '0;
        mb_q      <= {1'b1, i_data_two[22:0]};
        e1_q      <= i_data_one[30:23];
        e2_q      <= i_data_two[30:23];
        sign_q    <= i_data_one[31] ^ i_data_two[31];
        special_q <= special_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_32.sv
// Self-checking bench for fp_div_32: directed cases, handshake/reset scenarios and a
// randomized regression against an exact-rational RNE/FTZ division model.
module tb_fp_div_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] da;
  logic [31:0] db;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_div_zero;
  logic        o_invalid;

  int n_checks = 0;
  int n_fail   = 0;

  fp_div_32 #(.LOOP_BITS(26)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_data_one (da),
    .i_data_two (db),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_div_zero (o_div_zero),
    .o_invalid  (o_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact quotient Ma*2^30/Mb with its true remainder, RNE by tail comparison.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic dz, output logic inv);
    logic az, bz, ai, bi, an, bn, s;
    longint unsigned ma, mb, num, qq, rr, mant, disc, half;
    int e, sh;
    logic up;
    az = (a[30:23] == 0);
    bz = (b[30:23] == 0);
    ai = (a[30:23] == 8'hff) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hff) && (b[22:0] == 0);
    an = (a[30:23] == 8'hff) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hff) && (b[22:0] != 0);
    s   = a[31] ^ b[31];
    dz  = 1'b0;
    inv = 1'b0;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r = 32'h7fc00000; inv = 1'b1; return;
    end
    if (bz && !ai) begin
      r = {s, 31'h7f800000}; dz = 1'b1; return;
    end
    if (ai) begin r = {s, 31'h7f800000}; return; end
    if (bi || az) begin r = {s, 31'd0}; return; end
    ma  = 64'h800000 | 64'(a[22:0]);
    mb  = 64'h800000 | 64'(b[22:0]);
    num = ma << 30;
    qq  = num / mb;
    rr  = num % mb;
    if (qq >= (64'd1 << 30)) begin
      sh = 7; e = int'(a[30:23]) - int'(b[30:23]) + 127;
    end else begin
      sh = 6; e = int'(a[30:23]) - int'(b[30:23]) + 126;
    end
    mant = qq >> sh;
    disc = qq & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    up = (disc > half) || ((disc == half) && ((rr != 0) || mant[0]));
    mant = mant + 64'(up);
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23; e = e + 1;
    end
    if (e >= 255)     r = {s, 31'h7f800000};
    else if (e <= 0)  r = {s, 31'd0};
    else              r = {s, 8'(e), mant[22:0]};
  endfunction

  // Issue one start from IDLE and wait (bounded) for o_valid; lat = -1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] d,
                        output logic dz, output logic inv, output int lat);
    @(negedge clk);
    start = 1'b1; da = a; db = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (o_valid) begin lat = i; break; end
    end
    d = o_data; dz = o_div_zero; inv = o_invalid;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [1:0]  flags;  // {div_zero, invalid}
  } vec_t;

  vec_t vecs[$] = '{
    '{32'h40C00000, 32'h40000000, 32'h40400000, 2'b00},
    '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00},
    '{32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00},
    '{32'hBF800000, 32'h00000000, 32'hFF800000, 2'b10},
    '{32'h00000000, 32'h00000000, 32'h7FC00000, 2'b01},
    '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 2'b01},
    '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 2'b00},
    '{32'h00800000, 32'h40000000, 32'h00000000, 2'b00},
    '{32'h00400000, 32'h3F800000, 32'h00000000, 2'b00},
    '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2'b01},
    '{32'h7F800000, 32'h00000000, 32'h7F800000, 2'b00},
    '{32'h3F800000, 32'hFF800000, 32'h80000000, 2'b00},
    '{32'hC0000000, 32'h3F800000, 32'hC0000000, 2'b00},
    '{32'h80000000, 32'h3F800000, 32'h80000000, 2'b00}
  };

  initial begin
    logic [31:0] d, rq, a, b;
    logic        dz, inv, rdz, rinv, saw;
    int          lat, ea, eb;

    rst_n = 1'b0; start = 1'b0; da = '0; db = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", o_data, 32'd0);
    check("reset_ctrl", {28'd0, o_valid, o_busy, o_div_zero, o_invalid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Busy right after the start edge, then a single-cycle valid pulse.
    @(negedge clk);
    start = 1'b1; da = 32'h40C00000; db = 32'h40000000;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (o_valid) begin lat = i; break; end
    end
    check("first_latency", lat, 28);
    check("busy_drops_with_valid", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
    check("valid_one_cycle", {31'd0, o_valid}, 32'd0);
    check("data_held", o_data, 32'h40400000);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, d, dz, inv, lat);
      check($sformatf("vec%0d_data", i), d, vecs[i].q);
      check($sformatf("vec%0d_flags", i), {30'd0, dz, inv}, {30'd0, vecs[i].flags});
      check($sformatf("vec%0d_lat", i), lat, 28);
    end

    // Start pulse with new operands mid-operation is ignored.
    @(negedge clk);
    start = 1'b1; da = 32'h3F800000; db = 32'h40400000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; da = 32'h40C00000; db = 32'h40000000;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 11; i <= 45; i++) begin
      @(posedge clk); #1;
      if (o_valid) begin lat = i; break; end
    end
    check("ignored_start_lat", lat, 28);
    check("ignored_start_data", o_data, 32'h3EAAAAAB);
    saw = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (o_valid) saw = 1'b1;
    end
    check("ignored_start_not_queued", {31'd0, saw}, 32'd0);

    // Back-to-back: start held high through DONE picks up the second operand pair.
    @(negedge clk);
    start = 1'b1; da = 32'h40C00000; db = 32'h40000000;
    @(posedge clk);
    #1 begin da = 32'h3F800000; db = 32'h40400000; end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (o_valid) begin lat = i; break; end
    end
    start = 1'b0;
    check("b2b_first_lat", lat, 28);
    check("b2b_first_data", o_data, 32'h40400000);
    check("b2b_busy_held", {31'd0, o_busy}, 32'd1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (o_valid) begin lat = i; break; end
    end
    check("b2b_second_gap", lat, 28);
    check("b2b_second_data", o_data, 32'h3EAAAAAB);

    // Reset in the middle of an operation aborts it.
    run_op(32'hBF800000, 32'h00000000, d, dz, inv, lat);
    @(negedge clk);
    start = 1'b1; da = 32'h40C00000; db = 32'h40000000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_data", o_data, 32'd0);
    check("midreset_ctrl", {28'd0, o_valid, o_busy, o_div_zero, o_invalid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (o_valid) saw = 1'b1;
    end
    check("midreset_no_valid", {31'd0, saw}, 32'd0);
    run_op(32'h40C00000, 32'h40000000, d, dz, inv, lat);
    check("after_reset_data", d, 32'h40400000);
    check("after_reset_lat", lat, 28);

    // Random normal operands: half with exponents near bias, half over the full range.
    for (int n = 0; n < 1500; n++) begin
      if (n % 2 == 0) begin
        ea = int'($urandom_range(100, 154)); eb = int'($urandom_range(100, 154));
      end else begin
        ea = int'($urandom_range(1, 254)); eb = int'($urandom_range(1, 254));
      end
      a = {1'($urandom), 8'(ea), 23'($urandom)};
      b = {1'($urandom), 8'(eb), 23'($urandom)};
      ref_div(a, b, rq, rdz, rinv);
      run_op(a, b, d, dz, inv, lat);
      check($sformatf("rand%0d_%h_%h_data", n, a, b), d, rq);
      check($sformatf("rand%0d_flags", n), {30'd0, dz, inv}, {30'd0, rdz, rinv});
      check($sformatf("rand%0d_lat", n), lat, 28);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
